pipe_valid_ctrl: RTL and testbench

PIPE_VALID_CTRL -- requirements
Module: pipe_valid_ctrl

---
 rtl/pipe_valid_ctrl.sv | 103 ++++++++++
 tb/tb_pipe_valid_ctrl.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_valid_ctrl.sv
// pipe_valid_ctrl: per-stage valid bits, fetch-valid window counter and stall-deferred branch flush.
// Define PIPE_VALID_STATS_EN to add the saturating flush_cnt statistics output.
module pipe_valid_ctrl #(
  parameter int unsigned NUM_STAGES   = 4,
  parameter int unsigned FLUSH_DEPTH  = 2,
  parameter int unsigned VALID_WINDOW = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_mem_resp,
  input  logic                  dcache_stall,
  input  logic                  br_taken,
  output logic [NUM_STAGES-1:0] stage_valid,
  output logic                  fetch_window,
`ifdef PIPE_VALID_STATS_EN
  output logic [7:0]            flush_cnt,
`endif
  output logic                  flush_pend
);

  localparam int unsigned CntW = $clog2(VALID_WINDOW + 1);

  if (NUM_STAGES < 2 || NUM_STAGES > 8 || FLUSH_DEPTH < 1 || FLUSH_DEPTH > NUM_STAGES ||
      VALID_WINDOW < 1 || VALID_WINDOW > 15) begin : gen_param_check
    $error("pipe_valid_ctrl: illegal parameter combination");
  end

  logic [NUM_STAGES-1:0] stage_q, stage_d;
  logic [CntW-1:0]       win_q, win_d;
  logic                  pend_q, pend_d;
  logic                  adv;
  logic                  flush;

  assign adv          = !dcache_stall;
  assign flush        = adv && (br_taken || pend_q);
  assign fetch_window = (win_q != '0);
  assign stage_valid  = stage_q;
  assign flush_pend   = pend_q;

  always_comb begin
    stage_d = stage_q;
    if (adv) begin
      stage_d[0] = fetch_window && !flush;
      for (int i = 1; i < int'(NUM_STAGES); i++) begin
        stage_d[i] = (flush && i < int'(FLUSH_DEPTH)) ? 1'b0 : stage_q[i-1];
      end
    end
  end

  // A response reloads the window even while stalled; decrement only on advancing cycles.
  always_comb begin
    win_d = win_q;
    if (i_mem_resp) begin
      win_d = CntW'(VALID_WINDOW);
    end else if (adv && win_q != '0) begin
      win_d = win_q - CntW'(1);
    end
  end

  // A branch seen during a stall is remembered once and applied on the first advancing cycle.
  always_comb begin
    pend_d = pend_q;
    if (dcache_stall && br_taken) begin
      pend_d = 1'b1;
    end else if (adv) begin
      pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stage_q <= '0;
      win_q   <= '0;
      pend_q  <= 1'b0;
    end else begin
      stage_q <= stage_d;
      win_q   <= win_d;
      pend_q  <= pend_d;
    end
  end

`ifdef PIPE_VALID_STATS_EN
  logic [7:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    flush_cnt_d = flush_cnt_q;
    if (flush && flush_cnt_q != 8'hff) begin
      flush_cnt_d = flush_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      flush_cnt_q <= 8'd0;
    end else begin
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign flush_cnt = flush_cnt_q;
`endif

endmodule

// File: tb/tb_pipe_valid_ctrl.sv
// Self-checking bench for pipe_valid_ctrl: directed vector table plus randomized run
// against a queue-based reference model (flush_cnt checked when PIPE_VALID_STATS_EN is defined).
module tb_pipe_valid_ctrl;

  localparam int unsigned NS = 4;
  localparam int unsigned FD = 2;
  localparam int unsigned VW = 2;

  logic          clk = 1'b0;
  logic          rst, i_mem_resp, dcache_stall, br_taken;
  logic [NS-1:0] stage_valid;
  logic          fetch_window, flush_pend;
`ifdef PIPE_VALID_STATS_EN
  logic [7:0]    flush_cnt;
`endif

  pipe_valid_ctrl #(
    .NUM_STAGES  (NS),
    .FLUSH_DEPTH (FD),
    .VALID_WINDOW(VW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_mem_resp  (i_mem_resp),
    .dcache_stall(dcache_stall),
    .br_taken    (br_taken),
    .stage_valid (stage_valid),
    .fetch_window(fetch_window),
`ifdef PIPE_VALID_STATS_EN
    .flush_cnt   (flush_cnt),
`endif
    .flush_pend  (flush_pend)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rst;
    logic          resp;
    logic          stall;
    logic          br;
    logic [NS-1:0] exp_sv;
    logic          exp_fw;
    logic          exp_fp;
  } vec_t;

  vec_t vecs[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  // Reference model: window length, pending flag and a youngest-first queue of valid bits.
  int m_win;
  bit m_pend;
  bit m_pipe[$];
  int m_flushes;

  function automatic void model_reset();
    m_win = 0;
    m_pend = 0;
    m_flushes = 0;
    m_pipe.delete();
    for (int i = 0; i < int'(NS); i++) m_pipe.push_back(1'b0);
  endfunction

  function automatic void model_step(bit r, bit resp, bit stall, bit br);
    bit advance, kill;
    if (r) begin
      model_reset();
      return;
    end
    advance = !stall;
    kill    = advance && (br || m_pend);
    if (advance) begin
      m_pipe.push_front((m_win > 0) && !kill);
      void'(m_pipe.pop_back());
      if (kill) for (int i = 0; i < int'(FD); i++) m_pipe[i] = 1'b0;
    end
    if (kill && m_flushes < 255) m_flushes++;
    if (resp) m_win = VW;
    else if (advance && m_win > 0) m_win--;
    if (stall && br) m_pend = 1'b1;
    else if (advance) m_pend = 1'b0;
  endfunction

  function automatic logic [NS-1:0] model_sv();
    logic [NS-1:0] v;
    for (int i = 0; i < int'(NS); i++) v[i] = m_pipe[i];
    return v;
  endfunction

  task automatic check(string name, int idx, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0d: got %0h, expected %0h", name, idx, act, exp);
    end
  endtask

  task automatic drive_cycle(bit r, bit resp, bit stall, bit br);
    rst = r;
    i_mem_resp = resp;
    dcache_stall = stall;
    br_taken = br;
    @(posedge clk);
    #1;
    model_step(r, resp, stall, br);
  endtask

  task automatic add(bit r, bit resp, bit stall, bit br, logic [NS-1:0] sv, bit fw, bit fp);
    vec_t v;
    v.rst = r; v.resp = resp; v.stall = stall; v.br = br;
    v.exp_sv = sv; v.exp_fw = fw; v.exp_fp = fp;
    vecs.push_back(v);
  endtask

  initial begin
    rst = 1'b1; i_mem_resp = 1'b0; dcache_stall = 1'b0; br_taken = 1'b0;
    model_reset();

    // Reset for two cycles
    add(1, 0, 0, 0, 4'b0000, 0, 0);
    add(1, 0, 0, 0, 4'b0000, 0, 0);
    // Single response, then let it drain through the pipe
    add(0, 1, 0, 0, 4'b0000, 1, 0);
    add(0, 0, 0, 0, 4'b0001, 1, 0);
    add(0, 0, 0, 0, 4'b0011, 0, 0);
    add(0, 0, 0, 0, 4'b0110, 0, 0);
    add(0, 0, 0, 0, 4'b1100, 0, 0);
    add(0, 0, 0, 0, 4'b1000, 0, 0);
    add(0, 0, 0, 0, 4'b0000, 0, 0);
    // Fill with continuous responses, then a branch with a response in the same cycle
    add(0, 1, 0, 0, 4'b0000, 1, 0);
    add(0, 1, 0, 0, 4'b0001, 1, 0);
    add(0, 1, 0, 0, 4'b0011, 1, 0);
    add(0, 1, 0, 0, 4'b0111, 1, 0);
    add(0, 1, 0, 0, 4'b1111, 1, 0);
    add(0, 1, 0, 1, 4'b1100, 1, 0);
    add(0, 1, 0, 0, 4'b1001, 1, 0);
    add(0, 1, 0, 0, 4'b0011, 1, 0);
    add(0, 1, 0, 0, 4'b0111, 1, 0);
    add(0, 1, 0, 0, 4'b1111, 1, 0);
    // Branch during a 3-cycle stall is deferred until the stall drops
    add(0, 1, 1, 0, 4'b1111, 1, 0);
    add(0, 1, 1, 1, 4'b1111, 1, 1);
    add(0, 1, 1, 0, 4'b1111, 1, 1);
    add(0, 1, 0, 0, 4'b1100, 1, 0);
    // Refill, set up a pending flush, then reset mid-stall
    add(0, 1, 0, 0, 4'b1001, 1, 0);
    add(0, 1, 0, 0, 4'b0011, 1, 0);
    add(0, 1, 0, 0, 4'b0111, 1, 0);
    add(0, 1, 0, 0, 4'b1111, 1, 0);
    add(0, 1, 1, 1, 4'b1111, 1, 1);
    add(1, 1, 1, 1, 4'b0000, 0, 0);
    add(0, 0, 0, 0, 4'b0000, 0, 0);
    // Branch reasserted within one stall yields a single flush
    add(0, 1, 1, 1, 4'b0000, 1, 1);
    add(0, 1, 1, 1, 4'b0000, 1, 1);
    add(0, 0, 0, 0, 4'b0000, 1, 0);
    add(0, 0, 0, 0, 4'b0001, 0, 0);
    add(0, 0, 0, 0, 4'b0010, 0, 0);

    foreach (vecs[k]) begin
      drive_cycle(vecs[k].rst, vecs[k].resp, vecs[k].stall, vecs[k].br);
      check("vec_stage_valid", k, 32'(stage_valid), 32'(vecs[k].exp_sv));
      check("vec_fetch_window", k, 32'(fetch_window), 32'(vecs[k].exp_fw));
      check("vec_flush_pend", k, 32'(flush_pend), 32'(vecs[k].exp_fp));
    end

    // Randomized run against the reference model
    for (int c = 0; c < 3000; c++) begin
      drive_cycle(($urandom_range(63) == 0), ($urandom_range(1) == 1),
                  ($urandom_range(9) < 3), ($urandom_range(4) == 0));
      check("rnd_stage_valid", c, 32'(stage_valid), 32'(model_sv()));
      check("rnd_fetch_window", c, 32'(fetch_window), 32'(m_win > 0));
      check("rnd_flush_pend", c, 32'(flush_pend), 32'(m_pend));
`ifdef PIPE_VALID_STATS_EN
      check("rnd_flush_cnt", c, 32'(flush_cnt), 32'(m_flushes));
`endif
    end

`ifdef PIPE_VALID_STATS_EN
    drive_cycle(1, 0, 0, 0);
    check("stats_reset", 0, 32'(flush_cnt), 32'd0);
    for (int c = 0; c < 300; c++) drive_cycle(0, 1, 0, 1);
    check("stats_saturate", 300, 32'(flush_cnt), 32'd255);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
